// File: rtl/branch_predictor.sv
// Branch predictor for the fetch stage: 5-bit global history, 32-entry PHT of
// 2-bit saturating counters, and a 32-entry direct-mapped BTB.
// Optional feature macro: BP_GSHARE_EN -- when defined the PHT is indexed by
// pc[6:2] XOR BHR (gshare); when undefined the PHT is indexed by the BHR alone.
// Lookups are purely combinational; updates from EX land on the next rising
// edge and are never bypassed into a same-cycle lookup.
module branch_predictor (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] pred_next_pc,
    output logic        pred_taken,
    output logic [4:0]  pred_bhr,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic [4:0]  update_bhr
);

    localparam int ENTRIES = 32;

    logic [4:0]  bhr_q, bhr_d;
    logic [1:0]  pht_q        [ENTRIES];
    logic [1:0]  pht_d        [ENTRIES];
    logic        btb_valid_q  [ENTRIES];
    logic        btb_valid_d  [ENTRIES];
    logic [24:0] btb_tag_q    [ENTRIES];
    logic [24:0] btb_tag_d    [ENTRIES];
    logic [31:0] btb_target_q [ENTRIES];
    logic [31:0] btb_target_d [ENTRIES];

    logic [4:0]  lookup_btb_idx;
    logic [4:0]  lookup_pht_idx;
    logic [4:0]  update_btb_idx;
    logic [4:0]  update_pht_idx;
    logic        btb_hit;
    logic [31:0] pc_plus4;

    // Instruction-aligned PCs never carry information in their low two bits.
    logic unused_update_pc_bits;
    assign unused_update_pc_bits = ^update_pc[1:0];

    // Table indices for the fetch lookup and for the EX-stage update.
    always_comb begin
        lookup_btb_idx = current_pc[6:2];
        update_btb_idx = update_pc[6:2];
`ifdef BP_GSHARE_EN
        lookup_pht_idx = current_pc[6:2] ^ bhr_q;
        update_pht_idx = update_pc[6:2] ^ update_bhr;
`else
        lookup_pht_idx = bhr_q;
        update_pht_idx = update_bhr;
`endif
    end

    // Zero-latency prediction from the registered tables only.
    always_comb begin
        btb_hit      = btb_valid_q[lookup_btb_idx] &&
                       (btb_tag_q[lookup_btb_idx] == current_pc[31:7]);
        pred_taken   = btb_hit && pht_q[lookup_pht_idx][1];
        pc_plus4     = current_pc + 32'd4;
        pred_next_pc = pred_taken ? btb_target_q[lookup_btb_idx] : pc_plus4;
        pred_bhr     = bhr_q;
    end

    // Next-state for history, counters and BTB from the resolved branch.
    always_comb begin
        bhr_d = bhr_q;
        for (int i = 0; i < ENTRIES; i++) begin
            pht_d[i]        = pht_q[i];
            btb_valid_d[i]  = btb_valid_q[i];
            btb_tag_d[i]    = btb_tag_q[i];
            btb_target_d[i] = btb_target_q[i];
        end
        if (update_valid) begin
            if (update_taken) begin
                if (pht_q[update_pht_idx] != 2'b11) begin
                    pht_d[update_pht_idx] = pht_q[update_pht_idx] + 2'd1;
                end
                btb_valid_d[update_btb_idx]  = 1'b1;
                btb_tag_d[update_btb_idx]    = update_pc[31:7];
                btb_target_d[update_btb_idx] = update_target;
            end else begin
                if (pht_q[update_pht_idx] != 2'b00) begin
                    pht_d[update_pht_idx] = pht_q[update_pht_idx] - 2'd1;
                end
            end
            bhr_d = {bhr_q[3:0], update_taken};
        end
    end

    // Resettable state: reset wins over any update arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bhr_q <= 5'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i]       <= 2'b01;
                btb_valid_q[i] <= 1'b0;
            end
        end else begin
            bhr_q <= bhr_d;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i]       <= pht_d[i];
                btb_valid_q[i] <= btb_valid_d[i];
            end
        end
    end

    // BTB payload needs no reset because the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag_q[i]    <= btb_tag_d[i];
                btb_target_q[i] <= btb_target_d[i];
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a directed vector table for the
// training, saturation, tag, wrap, no-bypass and reset corner cases, followed
// by randomized traffic compared against a table-level reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic [4:0]  pred_bhr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [4:0]  update_bhr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .reset         (reset),
        .current_pc    (current_pc),
        .pred_next_pc  (pred_next_pc),
        .pred_taken    (pred_taken),
        .pred_bhr      (pred_bhr),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .update_bhr    (update_bhr)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [4:0]  ubhr;
        logic        etaken;
        logic [31:0] enext;
        logic [4:0]  ebhr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: counters as plain ints, BTB remembers the whole taken PC.
    int          m_bhr;
    int          m_pht   [32];
    bit          m_valid [32];
    logic [31:0] m_pc    [32];
    logic [31:0] m_tgt   [32];

    function automatic int modelIndex(input logic [31:0] pc, input int hist);
`ifdef BP_GSHARE_EN
        return int'((pc >> 2) & 32'h1F) ^ hist;
`else
        return hist;
`endif
    endfunction

    task automatic modelReset();
        m_bhr = 0;
        for (int i = 0; i < 32; i++) begin
            m_pht[i]   = 1;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic modelPredict(input logic [31:0] pc, output logic t,
                                output logic [31:0] n, output logic [4:0] b);
        int  slot;
        bit  hit;
        slot = int'((pc >> 2) & 32'h1F);
        hit  = m_valid[slot] && ((m_pc[slot] >> 7) == (pc >> 7));
        t    = hit && (m_pht[modelIndex(pc, m_bhr)] >= 2);
        n    = t ? m_tgt[slot] : pc + 32'd4;
        b    = 5'(m_bhr);
    endtask

    task automatic modelUpdate(input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic [4:0] ubhr);
        int idx;
        int slot;
        idx = modelIndex(upc, int'(ubhr));
        if (ut) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
        else    m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
        m_bhr = (m_bhr * 2 + int'(ut)) % 32;
        if (ut) begin
            slot         = int'((upc >> 2) & 32'h1F);
            m_valid[slot] = 1'b1;
            m_pc[slot]    = upc;
            m_tgt[slot]   = utgt;
        end
    endtask

    task automatic addVec(input string name, input logic rst, input logic [31:0] pc,
                          input logic uv, input logic [31:0] upc, input logic ut,
                          input logic [31:0] utgt, input logic [4:0] ubhr,
                          input logic etaken, input logic [31:0] enext, input logic [4:0] ebhr);
        vec_t v;
        v.name = name; v.rst = rst; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.ubhr = ubhr; v.etaken = etaken; v.enext = enext; v.ebhr = ebhr;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs just after the active edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] pc, input logic uv,
                                 input logic [31:0] upc, input logic ut,
                                 input logic [31:0] utgt, input logic [4:0] ubhr);
        @(posedge clk);
        #1;
        reset         = rst;
        current_pc    = pc;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utgt;
        update_bhr    = ubhr;
    endtask

    task automatic checkOutput(input string name, input logic et,
                               input logic [31:0] en, input logic [4:0] eb);
        checks++;
        if (pred_taken !== et) begin
            errors++;
            $display("[TB] FAIL %s pred_taken got %0b expected %0b", name, pred_taken, et);
        end
        checks++;
        if (pred_next_pc !== en) begin
            errors++;
            $display("[TB] FAIL %s pred_next_pc got %h expected %h", name, pred_next_pc, en);
        end
        checks++;
        if (pred_bhr !== eb) begin
            errors++;
            $display("[TB] FAIL %s pred_bhr got %0d expected %0d", name, pred_bhr, eb);
        end
    endtask

    function automatic logic [31:0] randPc();
        logic [24:0] tag;
        case ($urandom_range(0, 3))
            0:       tag = 25'h0;
            1:       tag = 25'h1;
            2:       tag = 25'h1FFFFFF;
            default: tag = 25'($urandom);
        endcase
        return {tag, 5'($urandom_range(0, 31)), 2'b00};
    endfunction

    initial begin
        logic        et;
        logic [31:0] en;
        logic [4:0]  eb;
        logic        rst;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [4:0]  ubhr;

        // Directed table; expected outputs are the lookup seen before the edge.
        addVec("post_reset",   0, 32'h100, 0, 32'h0,   0, 32'h0,  5'd0,  0, 32'h104, 5'd0);
        addVec("train1",       0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd0,  0, 32'h104, 5'd0);
        addVec("train2",       0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd1,  0, 32'h104, 5'd1);
        addVec("train_h3",     0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd3,  0, 32'h104, 5'd3);
        addVec("train_h7",     0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd7,  0, 32'h104, 5'd7);
        addVec("train_h15",    0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd15, 0, 32'h104, 5'd15);
        addVec("nobypass_old", 0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd31, 0, 32'h104, 5'd31);
        addVec("nobypass_new", 0, 32'h100, 0, 32'h0,   0, 32'h0,  5'd0,  1, 32'h40,  5'd31);
        for (int i = 0; i < 4; i++)
            addVec("sat_up",   0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd31, 1, 32'h40,  5'd31);
        addVec("sat_dec",      0, 32'h100, 1, 32'h100, 0, 32'hDEAD0000, 5'd31, 1, 32'h40, 5'd31);
        addVec("restore_a",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd30);
        addVec("restore_b",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd29);
        addVec("restore_c",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd27);
        addVec("restore_d",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd23);
        addVec("restore_e",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd15);
        addVec("ctr2_taken",   0, 32'h100, 0, 32'h0,   0, 32'h0,  5'd0,  1, 32'h40,  5'd31);
        addVec("dec_to1",      0, 32'h200, 1, 32'h100, 0, 32'hBAD0, 5'd31, 0, 32'h204, 5'd31);
        addVec("dec_to0",      0, 32'h200, 1, 32'h100, 0, 32'hBAD0, 5'd31, 0, 32'h204, 5'd30);
        addVec("inc_from0",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd31, 0, 32'h204, 5'd28);
        addVec("restore_f",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd25);
        addVec("restore_g",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd19);
        addVec("restore_h",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd7);
        addVec("restore_i",    0, 32'h200, 1, 32'h100, 1, 32'h40, 5'd10, 0, 32'h204, 5'd15);
        addVec("ctr1_ntaken",  0, 32'h100, 1, 32'h100, 1, 32'h40, 5'd31, 0, 32'h104, 5'd31);
        addVec("ctr2_again",   0, 32'h100, 0, 32'h0,   0, 32'h0,  5'd0,  1, 32'h40,  5'd31);
        addVec("tag_mismatch", 0, 32'h1100, 0, 32'h0,  0, 32'h0,  5'd0,  0, 32'h1104, 5'd31);
        addVec("wrap",         0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 5'd0, 0, 32'h0,  5'd31);
        addVec("reset_w_upd",  1, 32'h100, 1, 32'h100, 1, 32'h80, 5'd31, 1, 32'h40,  5'd31);
        addVec("after_reset",  0, 32'h100, 0, 32'h0,   0, 32'h0,  5'd0,  0, 32'h104, 5'd0);
        addVec("after_rst_wrap", 0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 5'd0, 0, 32'h0, 5'd0);
        addVec("after_rst_any", 0, 32'h12345678, 0, 32'h0, 0, 32'h0, 5'd0, 0, 32'h1234567C, 5'd0);

        reset = 1'b1; current_pc = '0; update_valid = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; update_bhr = '0;
        repeat (2) @(posedge clk);

        $display("[TB] directed vectors: %0d", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].pc, vecs[i].uv, vecs[i].upc,
                          vecs[i].ut, vecs[i].utgt, vecs[i].ubhr);
            @(negedge clk);
            checkOutput(vecs[i].name, vecs[i].etaken, vecs[i].enext, vecs[i].ebhr);
        end

        // Randomized traffic against the reference model, starting from reset.
        $display("[TB] random phase");
        modelReset();
        for (int i = 0; i < 1500; i++) begin
            rst  = (i == 0) || ($urandom_range(0, 63) == 0);
            pc   = ($urandom_range(0, 15) == 0) ? 32'($urandom) : randPc();
            uv   = ($urandom_range(0, 3) != 0);
            upc  = randPc();
            ut   = 1'($urandom);
            utgt = 32'($urandom);
            ubhr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(m_bhr);
            applyStimulus(rst, pc, uv, upc, ut, utgt, ubhr);
            @(negedge clk);
            if (i > 0) begin
                modelPredict(pc, et, en, eb);
                checkOutput($sformatf("rand%0d", i), et, en, eb);
            end
            if (rst) modelReset();
            else if (uv) modelUpdate(upc, ut, utgt, ubhr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
